// File: rtl/mcfsm_pkg.sv
// Shared types and constants for the multi-cycle control FSM.
package mcfsm_pkg;

  // Controller states; the 4-bit encoding is exported on the debug port.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  // Opcodes (low 4 bits of the opcode field)
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LW    = 4'd1;
  localparam logic [3:0] OP_SW    = 4'd2;
  localparam logic [3:0] OP_BEQ   = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_J     = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // ALU B operand select
  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  // Registered Moore strobes
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // True for states that do useful work (idle and terminal states excluded).
  function automatic logic is_busy_state(state_e s);
    return (s != S_IDLE) && (s != S_HALT) && (s != S_TRAP);
  endfunction

endpackage

// File: rtl/mcfsm_next_state.sv
// Combinational next-state decoder for the multi-cycle control FSM.
module mcfsm_next_state
  import mcfsm_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  state_e              state,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output state_e              state_nxt
);

  logic [3:0] op_lo;
  logic       op_hi_zero;

  // Only the low nibble is decoded; any set upper bit makes the opcode illegal.
  assign op_lo      = opcode[3:0];
  assign op_hi_zero = ((opcode >> 4) == '0);

  // Next-state selection; memory states hold until the handshake completes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (run) state_nxt = S_FETCH;
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!op_hi_zero) begin
          state_nxt = S_TRAP;
        end else begin
          case (op_lo)
            OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
            OP_RTYPE:     state_nxt = S_EXEC;
            OP_ADDI:      state_nxt = S_ADDI_EX;
            OP_BEQ:       state_nxt = S_BRANCH;
            OP_J:         state_nxt = S_JUMP;
            OP_HALT:      state_nxt = S_HALT;
            default:      state_nxt = S_TRAP;
          endcase
        end
      end
      S_MEM_ADDR: state_nxt = (op_lo == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_EXEC:     state_nxt = S_R_WB;
      S_ADDI_EX:  state_nxt = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                  state_nxt = S_FETCH;
      S_HALT, S_TRAP:
                  state_nxt = state;
      // Unused encoding: recover to idle.
      default:    state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback
// and drives per-state datapath strobes. Strobes are registered from the
// next state so they line up with the state register; ir_write and the
// fetch-time pc_write are qualified by mem_ready.
// Optional performance counters: define MCFSM_PERF_CNT_EN.
module multicycle_ctrl_fsm
  import mcfsm_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                halted,
  output logic                illegal,
  output logic [3:0]          state
`ifdef MCFSM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  if (OPCODE_W < 4) begin : g_bad_opcode_w
    $error("OPCODE_W must be at least 4");
  end
  if (ALUOP_W < 2) begin : g_bad_aluop_w
    $error("ALUOP_W must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  logic   fetch_done;

  mcfsm_next_state #(.OPCODE_W(OPCODE_W)) u_next_state (
    .state     (state_q),
    .run       (run),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .state_nxt (state_d)
  );

  // Strobe decode for the state being entered, plus sticky status bits.
  always_comb begin
    ctrl_d    = '0;
    halted_d  = halted_q | (state_d == S_HALT);
    illegal_d = illegal_q | (state_d == S_TRAP);
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.i_or_d    = 1'b0;
        ctrl_d.alu_src_a = 1'b0;
        ctrl_d.alu_src_b = SRCB_ONE;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut.
        ctrl_d.alu_src_a = 1'b0;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_dst    = 1'b0;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_B;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.mem_to_reg = 1'b0;
      end
      S_ADDI_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 1'b0;
        ctrl_d.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_B;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  // State register and registered outputs; reset aborts any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Fetch completes in the cycle memory answers; reset suppresses the pulse.
  assign fetch_done = (state_q == S_FETCH) & mem_ready & ~rst;

  assign ir_write      = fetch_done;
  assign pc_write      = ctrl_q.pc_write | fetch_done;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign pc_source     = ctrl_q.pc_source;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ALUOP_W'(ctrl_q.alu_op);
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign state         = state_q;

`ifdef MCFSM_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Busy-cycle count and retired-instruction count (re-entry into FETCH).
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (is_busy_state(state_q)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE))
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  // Counter registers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Expected behaviour comes from
// a per-instruction trace generator: each instruction expands into the list
// of states it must visit (with stall repeats), and each state maps to the
// strobes the control table requires.
module tb_multicycle_ctrl_fsm;
  import mcfsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halted, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
`ifdef MCFSM_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .halted(halted), .illegal(illegal), .state(state)
`ifdef MCFSM_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
  } strb_t;

  typedef struct {
    state_e     st;
    logic       rdy;
    logic       run;
    logic [3:0] op;
  } step_t;

  step_t tr[$];
  int n_cmp = 0, n_fail = 0;
  int seg_cyc = 0, ir_cnt = 0, mw_cnt = 0;
`ifdef MCFSM_PERF_CNT_EN
  int m_cyc = 0, m_instr = 0;
  state_e m_prev = S_IDLE;
`endif

  task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask

  function automatic strb_t obs_now();
    strb_t s;
    s.pc_write = pc_write; s.pc_write_cond = pc_write_cond;
    s.pc_source = pc_source; s.ir_write = ir_write; s.i_or_d = i_or_d;
    s.mem_read = mem_read; s.mem_write = mem_write; s.mem_to_reg = mem_to_reg;
    s.reg_dst = reg_dst; s.reg_write = reg_write; s.alu_src_a = alu_src_a;
    s.alu_src_b = alu_src_b; s.alu_op = alu_op;
    return s;
  endfunction

  // Control table: strobes required while sitting in state s.
  function automatic strb_t spec_strb(state_e s, logic rdy);
    strb_t x = '0;
    case (s)
      S_FETCH:   begin x.mem_read = 1; x.alu_src_b = 2'd1; x.ir_write = rdy; x.pc_write = rdy; end
      S_DECODE:  x.alu_src_b = 2'd2;
      S_MEM_ADDR, S_ADDI_EX: begin x.alu_src_a = 1; x.alu_src_b = 2'd2; end
      S_MEM_RD:  begin x.mem_read = 1; x.i_or_d = 1; end
      S_MEM_WB:  begin x.reg_write = 1; x.mem_to_reg = 1; end
      S_MEM_WR:  begin x.mem_write = 1; x.i_or_d = 1; end
      S_EXEC:    begin x.alu_src_a = 1; x.alu_op = 2'd2; end
      S_R_WB:    begin x.reg_write = 1; x.reg_dst = 1; end
      S_ADDI_WB: x.reg_write = 1;
      S_BRANCH:  begin x.alu_src_a = 1; x.alu_op = 2'd1; x.pc_write_cond = 1; x.pc_source = 2'd1; end
      S_JUMP:    begin x.pc_write = 1; x.pc_source = 2'd2; end
      default:   x = '0;
    endcase
    return x;
  endfunction

  task automatic push(state_e s, logic r, logic rn, logic [3:0] op);
    step_t e;
    e.st = s; e.rdy = r; e.run = rn; e.op = op;
    tr.push_back(e);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into the states it must visit.
  task automatic add_instr(logic [3:0] op, int fst, int mst, int tail);
    repeat (fst) push(S_FETCH, 1'b0, rbit(), op);
    push(S_FETCH, 1'b1, rbit(), op);
    push(S_DECODE, rbit(), rbit(), op);
    case (op)
      4'd0: begin push(S_EXEC, rbit(), rbit(), op); push(S_R_WB, rbit(), rbit(), op); end
      4'd1: begin
        push(S_MEM_ADDR, rbit(), rbit(), op);
        repeat (mst) push(S_MEM_RD, 1'b0, rbit(), op);
        push(S_MEM_RD, 1'b1, rbit(), op);
        push(S_MEM_WB, rbit(), rbit(), op);
      end
      4'd2: begin
        push(S_MEM_ADDR, rbit(), rbit(), op);
        repeat (mst) push(S_MEM_WR, 1'b0, rbit(), op);
        push(S_MEM_WR, 1'b1, rbit(), op);
      end
      4'd3: push(S_BRANCH, rbit(), rbit(), op);
      4'd4: begin push(S_ADDI_EX, rbit(), rbit(), op); push(S_ADDI_WB, rbit(), rbit(), op); end
      4'd5: push(S_JUMP, rbit(), rbit(), op);
      4'd15: repeat (tail) push(S_HALT, rbit(), rbit(), op);
      default: repeat (tail) push(S_TRAP, rbit(), rbit(), op);
    endcase
  endtask

  // Drive the trace one cycle per entry and check every cycle.
  task automatic run_trace();
    step_t e;
    while (tr.size() > 0) begin
      e = tr.pop_front();
      @(negedge clk);
      opcode = e.op; mem_ready = e.rdy; run = e.run;
      #1;
      seg_cyc++;
      if (ir_write) ir_cnt++;
      if (mem_write) mw_cnt++;
      chk("state", 32'(state), 32'(e.st));
      chk("strobes", 32'(obs_now()), 32'(spec_strb(e.st, e.rdy)));
      chk("halted", 32'(halted), 32'(e.st == S_HALT));
      chk("illegal", 32'(illegal), 32'(e.st == S_TRAP));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
`ifdef MCFSM_PERF_CNT_EN
      if (e.st == S_FETCH && m_prev != S_FETCH && m_prev != S_IDLE) m_instr++;
      chk("instr_cnt", instr_cnt, 32'(m_instr));
      chk("cycle_cnt", cycle_cnt, 32'(m_cyc));
      if (e.st != S_IDLE && e.st != S_HALT && e.st != S_TRAP) m_cyc++;
      m_prev = e.st;
`endif
    end
  endtask

  // Hold rst for n cycles with noisy inputs; everything must read as reset.
  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      #1;
      chk("rst_state", 32'(state), 32'(S_IDLE));
      chk("rst_strobes", 32'(obs_now()), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
    end
    rst = 1'b0; run = 1'b0;
`ifdef MCFSM_PERF_CNT_EN
    m_cyc = 0; m_instr = 0; m_prev = S_IDLE;
`endif
  endtask

  function automatic void seg_clear();
    seg_cyc = 0; ir_cnt = 0; mw_cnt = 0;
  endfunction

  initial begin
    logic [3:0] ops[6];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2;
    ops[3] = 4'd3; ops[4] = 4'd4; ops[5] = 4'd5;

    // Reset, idle hold, then one RTYPE
    do_reset(2);
    push(S_IDLE, 1'b1, 1'b0, 4'd0);
    push(S_IDLE, 1'b1, 1'b1, 4'd0);
    run_trace();
    seg_clear();
    add_instr(4'd0, 0, 0, 0);
    run_trace();
    chk("rtype_cycles", 32'(seg_cyc), 32'd4);

    // LW with 3 fetch stalls and 2 read stalls
    seg_clear();
    add_instr(4'd1, 3, 2, 0);
    run_trace();
    chk("lw_cycles", 32'(seg_cyc), 32'd10);
    chk("lw_ir_pulses", 32'(ir_cnt), 32'd1);

    // SW, BEQ, J back-to-back with no stalls
    seg_clear(); add_instr(4'd2, 0, 0, 0); run_trace();
    chk("sw_cycles", 32'(seg_cyc), 32'd4);
    chk("sw_write_cycles", 32'(mw_cnt), 32'd1);
    seg_clear(); add_instr(4'd3, 0, 0, 0); run_trace();
    chk("beq_cycles", 32'(seg_cyc), 32'd3);
    seg_clear(); add_instr(4'd5, 0, 0, 0); run_trace();
    chk("j_cycles", 32'(seg_cyc), 32'd3);

    // Random legal program with random stalls
    for (int i = 0; i < 40; i++)
      add_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), 0);
    run_trace();

    // Reset in the middle of a stalled store
    add_instr(4'd2, 0, 0, 0);
    void'(tr.pop_back());
    push(S_MEM_WR, 1'b0, 1'b0, 4'd2);
    push(S_MEM_WR, 1'b0, 1'b1, 4'd2);
    run_trace();
    do_reset(1);

    // Illegal opcode traps and stays trapped
    push(S_IDLE, 1'b0, 1'b1, 4'd7);
    add_instr(4'd7, 1, 0, 20);
    run_trace();
    do_reset(2);

    // HALT is sticky until reset
    push(S_IDLE, 1'b0, 1'b1, 4'd15);
    add_instr(4'd15, 0, 0, 5);
    run_trace();
    do_reset(2);
    push(S_IDLE, 1'b1, 1'b0, 4'd0);
    push(S_IDLE, 1'b1, 1'b0, 4'd0);
    run_trace();

    // Three RTYPE then HALT
    push(S_IDLE, 1'b1, 1'b1, 4'd0);
    repeat (3) add_instr(4'd0, 0, 0, 0);
    add_instr(4'd15, 0, 0, 3);
    run_trace();
`ifdef MCFSM_PERF_CNT_EN
    chk("perf_instr_total", instr_cnt, 32'd3);
    chk("perf_cycle_total", cycle_cnt, 32'd14);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised multi-cycle control unit that supersedes the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives per-state datapath strobes.
- Stalls on a memory-ready handshake.
- Sits between the multi-cycle datapath (opcode source, memory port) and the CPU top.

Parameters:
OPCODE_W, 4, opcode field width; the decode table uses the low 4 bits, and any other upper bits must be zero or the opcode is illegal.
ALUOP_W, 2, ALU operation select width.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
run  in  1  leave IDLE and begin fetching
opcode  in  OPCODE_W  instruction register opcode field
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_source  out  2  0=ALU result, 1=ALUOut register, 2=jump target
ir_write  out  1  instruction register load
i_or_d  out  1  0=instruction address, 1=data address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  writeback source is MDR
reg_dst  out  1  destination is rd (else rt)
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  0=B, 1=constant 1, 2=sign-extended immediate
alu_op  out  ALUOP_W  0=add, 1=sub, 2=funct-decoded
halted  out  1  sticky, set on HALT
illegal  out  1  sticky, set on unknown opcode
state  out  4  current state encoding, for debug

Behaviour:
- All outputs are Moore outputs, decoded from the registered state, except where noted. Inactive strobes are 0.
- Reset: state=IDLE, all strobes 0, halted=0, illegal=0. A reset asserted mid-instruction aborts on the next edge; no partial write strobe survives.
- Opcodes: 0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 15=HALT. All others are illegal.
- IDLE: wait for run=1, then go to FETCH.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - ir_write and pc_write are Mealy, qualified by mem_ready: asserted only in the cycle mem_ready=1.
  - mem_ready=0: hold in FETCH.
  - mem_ready=1: go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=2, alu_op=add (branch target into ALUOut).
  - Next state: LW/SW->MEM_ADDR; RTYPE->EXEC; ADDI->ADDI_EX; BEQ->BRANCH; J->JUMP; HALT->HALT; other->TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=add. LW->MEM_RD, SW->MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=2, alu_op=add. Go to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_source=1. Go to FETCH.
- JUMP: pc_write=1, pc_source=2. Go to FETCH.
- HALT: halted=1 (sticky). Absorbing until rst.
- TRAP: illegal=1 (sticky). Absorbing until rst.
- Latency in cycles with mem_ready tied 1: RTYPE 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored in states with no outstanding request.
- run is sampled only in IDLE; deasserting it mid-program has no effect.
- mem_read and mem_write are never asserted in the same cycle.

Optional Feature:
- Macro: MCFSM_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt and instr_cnt, each CNT_W bits, reset to 0.
  - cycle_cnt increments every cycle the state is not IDLE, HALT or TRAP.
  - instr_cnt increments on each transition into FETCH from a completing state.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Package mcfsm_pkg holds:
  - the state enum, 4 bits;
  - the opcode constants OP_RTYPE..OP_HALT;
  - the ALU-op constants ALU_ADD, ALU_SUB, ALU_FUNCT;
  - the pc_source and alu_src_b encodings.
- One natural sub-module: mcfsm_next_state, a combinational next-state decoder taking state, opcode and mem_ready.
- Output decode stays in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then run=1, opcode=0, mem_ready=1 → state sequence IDLE,FETCH,DECODE,EXEC,R_WB,FETCH; reg_write=1 and reg_dst=1 only in R_WB.
- LW with stalls: opcode=1, mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEM_RD → 10 cycles FETCH-to-FETCH; ir_write pulses exactly once; reg_write=1, mem_to_reg=1 in MEM_WB.
- SW, BEQ, J back-to-back with mem_ready=1 → 4, 3, 3 cycles respectively:
  - SW: mem_write=1 for exactly 1 cycle.
  - BEQ: pc_write_cond=1, pc_source=1.
  - J: pc_write=1, pc_source=2.
- opcode=7 → TRAP after DECODE; illegal=1 and held for 20 cycles; no strobes.
- opcode=15 → HALT; halted=1. A later rst=1 clears halted and returns the FSM to IDLE.
- With MCFSM_PERF_CNT_EN: 3 RTYPE instructions then HALT → instr_cnt=3, cycle_cnt=14.
